// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - HC-SR04 trigger/echo timer producing a hysteretic tooClose flag
// Optional RANGER_FILTER_EN: tooClose only moves after two consecutive results agree on the new value.
module ultrasonic_ranger #(
  parameter int unsigned CLK_PER_US      = 100,
  parameter int unsigned TRIG_US         = 10,
  parameter int unsigned ECHO_TIMEOUT_US = 30000,
  parameter int unsigned CYCLE_US        = 60000,
  parameter int unsigned NEAR_US         = 580,
  parameter int unsigned HYST_US         = 116
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        echo,
  output logic        trigger,
  output logic        tooClose,
  output logic [15:0] echoUs,
  output logic        distValid,
  output logic        timeout
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_MAX    = PW'(CLK_PER_US - 1);
  localparam logic [15:0]   TRIG_LAST    = 16'(TRIG_US - 1);
  localparam logic [15:0]   TIMEOUT_LAST = 16'(ECHO_TIMEOUT_US - 1);
  localparam logic [15:0]   CYCLE_LAST   = 16'(CYCLE_US - 1);
  localparam logic [15:0]   CYCLE_END    = 16'(CYCLE_US);
  localparam logic [15:0]   NEAR_LIM     = 16'(NEAR_US);
  localparam logic [15:0]   FAR_LIM      = 16'(NEAR_US + HYST_US);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] cyc_presc_q, cyc_presc_d;
  logic [15:0]   us_q, us_d;
  logic [15:0]   cyc_us_q, cyc_us_d;
  logic [15:0]   echo_us_q, echo_us_d;
  logic          echo_s1_q, echo_s2_q, echo_prev_q;
  logic          trigger_q, trigger_d;
  logic          too_close_q, too_close_d;
  logic          dist_valid_q, dist_valid_d;
  logic          timeout_q, timeout_d;
`ifdef RANGER_FILTER_EN
  logic          pend_q, pend_d;
`endif

  logic        tick, cyc_tick, echo_rise, echo_fall, entering, cycle_done;
  logic        res_valid, res_to, req_tc;
  logic [15:0] us_inc, us_now;

  assign tick       = (presc_q == PRESC_MAX);
  assign cyc_tick   = (cyc_presc_q == PRESC_MAX);
  assign echo_rise  = echo_s2_q & ~echo_prev_q;
  assign echo_fall  = ~echo_s2_q & echo_prev_q;
  assign us_inc     = (us_q == 16'hFFFF) ? us_q : us_q + 16'd1;
  // Width including the microsecond that completes in this very cycle.
  assign us_now     = tick ? us_inc : us_q;
  // A late HOLDOFF entry (long wait plus long echo) must not stall the schedule.
  assign cycle_done = (cyc_us_q >= CYCLE_END) || (cyc_tick && (cyc_us_q == CYCLE_LAST));
  assign entering   = (state_d != state_q);

  always_comb begin
    state_d   = state_q;
    res_valid = 1'b0;
    res_to    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (tick && (us_q == TRIG_LAST)) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (echo_rise) begin
          state_d = S_MEASURE;
        end else if (tick && (us_q == TIMEOUT_LAST)) begin
          state_d = S_HOLDOFF;
          res_to  = 1'b1;
        end
      end
      S_MEASURE: begin
        if (echo_fall) begin
          state_d   = S_HOLDOFF;
          res_valid = 1'b1;
        end else if (tick && (us_q == TIMEOUT_LAST)) begin
          state_d = S_HOLDOFF;
          res_to  = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (cycle_done) state_d = enable ? S_TRIG : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    echo_us_d    = echo_us_q;
    dist_valid_d = 1'b0;
    timeout_d    = 1'b0;
    too_close_d  = too_close_q;
    req_tc       = too_close_q;
    trigger_d    = (state_d == S_TRIG);
`ifdef RANGER_FILTER_EN
    pend_d       = pend_q;
`endif
    if (res_valid) begin
      echo_us_d    = us_now;
      dist_valid_d = 1'b1;
      if (us_now < NEAR_LIM)      req_tc = 1'b1;
      else if (us_now >= FAR_LIM) req_tc = 1'b0;
    end else if (res_to) begin
      echo_us_d = 16'hFFFF;
      timeout_d = 1'b1;
      req_tc    = 1'b0;
    end
`ifdef RANGER_FILTER_EN
    if (res_valid || res_to) begin
      if (req_tc == too_close_q) begin
        pend_d = 1'b0;
      end else if (pend_q) begin
        too_close_d = req_tc;
        pend_d      = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
`else
    too_close_d = req_tc;
`endif
  end

  // State timer restarts on every state entry; the cycle timer runs from TRIG entry only.
  always_comb begin
    presc_d     = (entering || tick) ? '0 : presc_q + PW'(1);
    us_d        = entering ? 16'd0 : (tick ? us_inc : us_q);
    cyc_presc_d = cyc_tick ? '0 : cyc_presc_q + PW'(1);
    cyc_us_d    = (cyc_tick && (cyc_us_q != 16'hFFFF)) ? cyc_us_q + 16'd1 : cyc_us_q;
    if ((state_q == S_IDLE) || (entering && (state_d == S_TRIG))) begin
      cyc_presc_d = '0;
      cyc_us_d    = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      cyc_presc_q  <= '0;
      us_q         <= 16'd0;
      cyc_us_q     <= 16'd0;
      echo_us_q    <= 16'd0;
      echo_s1_q    <= 1'b0;
      echo_s2_q    <= 1'b0;
      echo_prev_q  <= 1'b0;
      trigger_q    <= 1'b0;
      too_close_q  <= 1'b0;
      dist_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef RANGER_FILTER_EN
      pend_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cyc_presc_q  <= cyc_presc_d;
      us_q         <= us_d;
      cyc_us_q     <= cyc_us_d;
      echo_us_q    <= echo_us_d;
      echo_s1_q    <= echo;
      echo_s2_q    <= echo_s1_q;
      echo_prev_q  <= echo_s2_q;
      trigger_q    <= trigger_d;
      too_close_q  <= too_close_d;
      dist_valid_q <= dist_valid_d;
      timeout_q    <= timeout_d;
`ifdef RANGER_FILTER_EN
      pend_q       <= pend_d;
`endif
    end
  end

  assign trigger   = trigger_q;
  assign tooClose  = too_close_q;
  assign echoUs    = echo_us_q;
  assign distValid = dist_valid_q;
  assign timeout   = timeout_q;

endmodule
